// File: rtl/hazard_if.sv
// Pipeline-side bundle for the hazard unit: register numbers and control bits in,
// forwarding selects, stall/flush and multiply/divide status out.
interface hazard_if #(
    parameter int CNTW = 16
);
    logic [4:0]      rsD, rtD, rsE, rtE;
    logic [4:0]      writeregE, writeregM, writeregW;
    logic            regwriteE, regwriteM, regwriteW;
    logic            memtoregE, memtoregM;
    logic            branchD;
    logic            mdstartD, mdstartE, mdreadD;
    logic [1:0]      forwardAE, forwardBE;
    logic            forwardAD, forwardBD;
    logic            stallF, stallD, flushE;
    logic            mdbusy;
    logic [CNTW-1:0] stallcount;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, mdstartD, mdstartE, mdreadD,
        input  forwardAE, forwardBE, forwardAD, forwardBD,
               stallF, stallD, flushE, mdbusy, stallcount
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, mdstartD, mdstartE, mdreadD,
        output forwardAE, forwardBE, forwardAD, forwardBD,
               stallF, stallD, flushE, mdbusy, stallcount
    );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use / branch / mul-div
// stall detection, a multiply/divide busy timer and a saturating stall counter.
module hazard_unit #(
    parameter int MDLAT = 4,
    parameter int CNTW  = 16
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hu
);
    localparam logic [3:0] MDLAT_L = 4'(MDLAT);

    logic [3:0]      mdcnt;
    logic [CNTW-1:0] stallcnt;
    logic [1:0]      fae, fbe;
    logic            fad, fbd;
    logic            lwstall, branchstall, mdstall, stall;

    // M-stage result wins over W since it is the younger producer.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] wm,
        input logic       rwm,
        input logic [4:0] ww,
        input logic       rww
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0 && src == wm && rwm)
            sel = 2'd2;
        else if (src != 5'd0 && src == ww && rww)
            sel = 2'd1;
        return sel;
    endfunction

    always_comb begin
        fae = fwd_sel(hu.rsE, hu.writeregM, hu.regwriteM, hu.writeregW, hu.regwriteW);
        fbe = fwd_sel(hu.rtE, hu.writeregM, hu.regwriteM, hu.writeregW, hu.regwriteW);
        fad = (hu.rsD != 5'd0) && (hu.rsD == hu.writeregM) && hu.regwriteM;
        fbd = (hu.rtD != 5'd0) && (hu.rtD == hu.writeregM) && hu.regwriteM;
    end

    assign lwstall = hu.memtoregE & ((hu.rsD == hu.rtE) | (hu.rtD == hu.rtE));

    assign branchstall = hu.branchD &
        ((hu.regwriteE & ((hu.writeregE == hu.rsD) | (hu.writeregE == hu.rtD))) |
         (hu.memtoregM & ((hu.writeregM == hu.rsD) | (hu.writeregM == hu.rtD))));

    // A mul/div entering E this cycle counts as busy for the D instruction behind it.
    assign mdstall = (hu.mdreadD | hu.mdstartD) & ((mdcnt != 4'd0) | hu.mdstartE);
    assign stall   = lwstall | branchstall | mdstall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mdcnt <= 4'd0;
        else if (hu.mdstartE)
            mdcnt <= MDLAT_L;
        else if (mdcnt != 4'd0)
            mdcnt <= mdcnt - 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stallcnt <= '0;
        else if (stall && stallcnt != '1)
            stallcnt <= stallcnt + 1'b1;
    end

    assign hu.forwardAE  = fae;
    assign hu.forwardBE  = fbe;
    assign hu.forwardAD  = fad;
    assign hu.forwardBD  = fbd;
    assign hu.stallF     = stall;
    assign hu.stallD     = stall;
    assign hu.flushE     = stall;
    assign hu.mdbusy     = (mdcnt != 4'd0);
    assign hu.stallcount = stallcnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: vector table plus multi-cycle sequences, expectations queued
// per cycle and compared before the next rising edge; a CNTW=4 copy shares the stimulus.
module tb_hazard_unit;
    localparam int MDLAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_if #(.CNTW(16)) hif ();
    hazard_if #(.CNTW(4))  hif4 ();

    hazard_unit #(.MDLAT(MDLAT), .CNTW(16)) dut  (.clk(clk), .reset(reset), .hu(hif));
    hazard_unit #(.MDLAT(MDLAT), .CNTW(4))  dut4 (.clk(clk), .reset(reset), .hu(hif4));

    assign hif4.rsD = hif.rsD;             assign hif4.rtD = hif.rtD;
    assign hif4.rsE = hif.rsE;             assign hif4.rtE = hif.rtE;
    assign hif4.writeregE = hif.writeregE; assign hif4.writeregM = hif.writeregM;
    assign hif4.writeregW = hif.writeregW; assign hif4.regwriteE = hif.regwriteE;
    assign hif4.regwriteM = hif.regwriteM; assign hif4.regwriteW = hif.regwriteW;
    assign hif4.memtoregE = hif.memtoregE; assign hif4.memtoregM = hif.memtoregM;
    assign hif4.branchD = hif.branchD;     assign hif4.mdstartD = hif.mdstartD;
    assign hif4.mdstartE = hif.mdstartE;   assign hif4.mdreadD = hif.mdreadD;

    typedef struct {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW, mtrE, mtrM, brD, mdsD, mdsE, mdrD;
        logic [1:0] fae, fbe;
        logic       fad, fbd, stall;
    } vec_t;

    typedef struct {
        string      tag;
        logic [1:0] fae, fbe;
        logic       fad, fbd, stall, busy;
        int         cnt;
    } exp_t;

    vec_t v;
    vec_t tbl[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cnt_model = 0;
    int   md_model = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        v = '{default: '0};
    endtask

    task automatic drive(input vec_t t);
        hif.rsD = t.rsD;         hif.rtD = t.rtD;
        hif.rsE = t.rsE;         hif.rtE = t.rtE;
        hif.writeregE = t.wE;    hif.writeregM = t.wM;    hif.writeregW = t.wW;
        hif.regwriteE = t.rwE;   hif.regwriteM = t.rwM;   hif.regwriteW = t.rwW;
        hif.memtoregE = t.mtrE;  hif.memtoregM = t.mtrM;
        hif.branchD = t.brD;
        hif.mdstartD = t.mdsD;   hif.mdstartE = t.mdsE;   hif.mdreadD = t.mdrD;
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: no expectation queued");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".forwardAE"}, int'(hif.forwardAE), int'(e.fae));
        chk({e.tag, ".forwardBE"}, int'(hif.forwardBE), int'(e.fbe));
        chk({e.tag, ".forwardAD"}, int'(hif.forwardAD), int'(e.fad));
        chk({e.tag, ".forwardBD"}, int'(hif.forwardBD), int'(e.fbd));
        chk({e.tag, ".stallF"}, int'(hif.stallF), int'(e.stall));
        chk({e.tag, ".stallD"}, int'(hif.stallD), int'(e.stall));
        chk({e.tag, ".flushE"}, int'(hif.flushE), int'(e.stall));
        chk({e.tag, ".mdbusy"}, int'(hif.mdbusy), int'(e.busy));
        chk({e.tag, ".stallcount"}, int'(hif.stallcount), e.cnt);
        chk({e.tag, ".stallcount4"}, int'(hif4.stallcount), (e.cnt > 15) ? 15 : e.cnt);
    endtask

    // One pipeline cycle: drive after the falling edge, compare just before the rising edge,
    // then advance the reference counters by what this cycle should have done.
    task automatic run(input vec_t t, input string tag);
        exp_t e;
        @(negedge clk);
        drive(t);
        e.tag = tag;
        e.fae = t.fae;  e.fbe = t.fbe;
        e.fad = t.fad;  e.fbd = t.fbd;
        e.stall = t.stall;
        e.busy = (md_model != 0);
        e.cnt = cnt_model;
        sb.push_back(e);
        #3;
        check_out();
        @(posedge clk);
        if (t.stall && cnt_model < 65535) cnt_model++;
        if (t.mdsE) md_model = MDLAT;
        else if (md_model > 0) md_model--;
    endtask

    // Reset pulse fully between two rising edges, with idle inputs so the edge after it is quiet.
    task automatic mid_reset(input bit precheck, input string tag);
        @(negedge clk);
        clr();
        drive(v);
        if (precheck) begin
            chk({tag, ".pre_mdbusy"}, int'(hif.mdbusy), 1);
            chk({tag, ".pre_stallcount"}, int'(hif.stallcount), 7);
        end
        #1 reset = 1'b0;
        #1;
        chk({tag, ".rst_mdbusy"}, int'(hif.mdbusy), 0);
        chk({tag, ".rst_stallcount"}, int'(hif.stallcount), 0);
        chk({tag, ".rst_stallcount4"}, int'(hif4.stallcount), 0);
        #1 reset = 1'b1;
        md_model = 0;
        cnt_model = 0;
    endtask

    initial begin
        // Reset held from time 0: counters clear, forwarding still live, no md stall.
        clr();
        v.rsE = 5; v.wM = 5; v.rwM = 1; v.mdrD = 1;
        drive(v);
        repeat (2) @(posedge clk);
        #2;
        chk("reset.mdbusy", int'(hif.mdbusy), 0);
        chk("reset.stallcount", int'(hif.stallcount), 0);
        chk("reset.stallcount4", int'(hif4.stallcount), 0);
        chk("reset.forwardAE", int'(hif.forwardAE), 2);
        chk("reset.stallD", int'(hif.stallD), 0);
        @(negedge clk);
        clr();
        drive(v);
        reset = 1'b1;

        clr(); v.rsE = 5; v.wM = 5; v.rwM = 1; v.wW = 5; v.rwW = 1; v.fae = 2; tbl.push_back(v);
        v.rwM = 0; v.fae = 1; tbl.push_back(v);
        v.rsE = 0; v.fae = 0; tbl.push_back(v);
        clr(); v.rtE = 7; v.wW = 7; v.rwW = 1; v.wM = 7; v.fbe = 1; tbl.push_back(v);
        clr(); v.rtE = 9; v.wM = 9; v.rwM = 1; v.fbe = 2; tbl.push_back(v);
        clr(); v.rsE = 4; v.rtE = 4; v.wM = 4; v.rwM = 1; v.wW = 4; v.rwW = 1;
               v.fae = 2; v.fbe = 2; tbl.push_back(v);
        clr(); v.wM = 0; v.rwM = 1; v.wW = 0; v.rwW = 1; tbl.push_back(v);
        clr(); v.rsD = 6; v.wM = 6; v.rwM = 1; v.fad = 1; tbl.push_back(v);
        clr(); v.rsD = 6; v.rtD = 6; v.wM = 6; tbl.push_back(v);
        clr(); v.rtD = 12; v.wM = 12; v.rwM = 1; v.fbd = 1; tbl.push_back(v);
        clr(); v.mtrE = 1; v.rtE = 8; v.rsD = 8; v.rtD = 1; v.stall = 1; tbl.push_back(v);
        clr(); v.mtrE = 1; v.rtE = 8; v.rsD = 2; v.rtD = 8; v.stall = 1; tbl.push_back(v);
        clr(); v.mtrE = 1; v.rtE = 8; v.rsD = 2; v.rtD = 3; tbl.push_back(v);
        clr(); v.rtE = 8; v.rsD = 8; tbl.push_back(v);
        clr(); v.brD = 1; v.rsD = 2; v.rtD = 3; v.wE = 3; v.rwE = 1; v.stall = 1; tbl.push_back(v);
        clr(); v.brD = 1; v.rsD = 2; v.rtD = 3; v.wM = 3; v.rwM = 1; v.fbd = 1; tbl.push_back(v);
        clr(); v.brD = 1; v.rsD = 10; v.rtD = 11; v.wM = 10; v.rwM = 1; v.mtrM = 1;
               v.fad = 1; v.stall = 1; tbl.push_back(v);
        clr(); v.brD = 1; v.rsD = 10; v.wE = 10; tbl.push_back(v);
        clr(); v.rsD = 10; v.wE = 10; v.rwE = 1; tbl.push_back(v);
        clr(); v.mtrE = 1; v.rtE = 8; v.rsD = 8; v.brD = 1; v.wE = 8; v.rwE = 1;
               v.mdsD = 1; v.mdsE = 1; v.stall = 1; tbl.push_back(v);

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // Let the mul/div started by the last vector drain, then the mfhi-behind-mult case.
        clr();
        repeat (5) run(v, "drain");
        v.mdsE = 1; v.mdrD = 1; v.stall = 1; run(v, "md.start");
        v.mdsE = 0;
        for (int i = 0; i < 4; i++) run(v, $sformatf("md.busy%0d", i));
        v.stall = 0; run(v, "md.done");

        // Back-to-back mul/div restarts the latency.
        clr(); v.mdsE = 1; run(v, "reload.a");
        clr(); run(v, "reload.gap");
        v.mdsE = 1; run(v, "reload.b");
        clr(); v.mdsD = 1; v.stall = 1;
        for (int i = 0; i < 4; i++) run(v, $sformatf("reload.busy%0d", i));
        v.stall = 0; run(v, "reload.done");

        // Saturation of the 4-bit counter copy.
        mid_reset(1'b0, "sat");
        clr(); v.mtrE = 1; v.rtE = 8; v.rsD = 8; v.stall = 1;
        for (int i = 0; i < 20; i++) run(v, $sformatf("sat%0d", i));
        clr(); run(v, "sat.hold");
        chk("sat.final4", int'(hif4.stallcount), 15);

        // Abort a mul/div and clear the counter with a reset pulse between edges.
        mid_reset(1'b0, "abort.init");
        clr(); v.mtrE = 1; v.rtE = 8; v.rsD = 8; v.stall = 1;
        repeat (7) run(v, "abort.stall");
        clr(); v.mdsE = 1; run(v, "abort.mdstart");
        mid_reset(1'b1, "abort");
        clr();
        repeat (3) run(v, "abort.after");

        chk("scoreboard.drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MDLAT, default 4, giving multiply/divide latency in cycles (legal 2..15).
REQ-002 SHALL have parameter CNTW, default 16, giving stall-counter width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 rsD, rtD  input  5 each  source register numbers of the Decode-stage instruction.
REQ-006 rsE, rtE  input  5 each  source register numbers of the Execute-stage instruction.
REQ-007 writeregE, writeregM, writeregW  input  5 each  destination register numbers in E/M/W.
REQ-008 regwriteE, regwriteM, regwriteW  input  1 each  destination register write enable in E/M/W.
REQ-009 memtoregE, memtoregM  input  1 each  the E/M instruction is a load.
REQ-010 branchD  input  1  the D instruction is a branch resolved in D.
REQ-011 mdstartD, mdstartE  input  1 each  the D/E instruction starts a multiply/divide.
REQ-012 mdreadD  input  1  the D instruction reads HI/LO (mfhi/mflo).
REQ-013 forwardAE, forwardBE  output  2 each  ALU operand select: 0 = register file, 1 = W result, 2 = M ALU result; 3 is never driven.
REQ-014 forwardAD, forwardBD  output  1 each  branch comparator operand select: 1 = M ALU result.
REQ-015 stallF, stallD, flushE  output  1 each  hold PC, hold IF/ID register, clear ID/EX register.
REQ-016 mdbusy  output  1  multiply/divide unit busy.
REQ-017 stallcount  output  CNTW  saturating count of stall cycles.

Function
REQ-018 forwardAE SHALL be 2 when rsE!=0, rsE==writeregM and regwriteM; otherwise 1 when rsE!=0, rsE==writeregW and regwriteW; otherwise 0. M has priority over W.
REQ-019 forwardBE SHALL follow REQ-018 with rtE in place of rsE.
REQ-020 forwardAD SHALL be 1 only when rsD!=0, rsD==writeregM and regwriteM; forwardBD SHALL be the same with rtD.
REQ-021 lwstall SHALL be memtoregE & ((rsD==rtE) | (rtD==rtE)).
REQ-022 branchstall SHALL be branchD & ((regwriteE & (writeregE==rsD | writeregE==rtD)) | (memtoregM & (writeregM==rsD | writeregM==rtD))).
REQ-023 An internal counter mdcnt (4 bits) SHALL load MDLAT on a rising edge where mdstartE=1, and otherwise decrement on each edge while nonzero; a mdstartE arriving while mdcnt!=0 SHALL reload MDLAT.
REQ-024 mdbusy SHALL equal (mdcnt!=0), combinationally from the register.
REQ-025 mdstall SHALL be (mdreadD | mdstartD) & (mdbusy | mdstartE).
REQ-026 stallF, stallD and flushE SHALL each equal lwstall | branchstall | mdstall, combinationally, with zero-cycle latency.
REQ-027 stallcount SHALL increment by 1 on each rising edge where stallD=1 and SHALL hold at all-ones (saturate) without wrapping.
REQ-028 All outputs except mdbusy and stallcount SHALL be purely combinational from the inputs and mdcnt; no combinational path SHALL exist from any output back to an input.
REQ-029 Simultaneous lwstall, branchstall and mdstall SHALL produce one stall cycle per edge (OR), counted once.

Reset
REQ-030 reset=0 SHALL immediately clear mdcnt and stallcount to 0, independent of clk.
REQ-031 While reset=0, mdbusy SHALL be 0, stallcount SHALL be 0, and the combinational outputs SHALL follow REQ-018..REQ-026 with mdcnt=0.
REQ-032 Reset asserted mid multiply/divide SHALL abort it: mdbusy drops in the same cycle and does not reassert after release unless mdstartE=1 is sampled.

Verification
REQ-033 rsE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1 -> forwardAE=2; drop regwriteM -> forwardAE=1; set rsE=0 -> forwardAE=0.
REQ-034 memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1 for that cycle; stallcount increments by 1 at the next edge.
REQ-035 branchD=1, rtD=3, writeregE=3, regwriteE=1 -> stall=1; next cycle the producer is in M with regwriteM=1, memtoregM=0 -> stall=0, forwardBD=1.
REQ-036 MDLAT=4: mdstartE pulse at edge 0 -> mdbusy=1 after edges 0..3, 0 after edge 4; mdreadD held high -> stallD=1 during the cycle mdstartE=1 and while mdbusy=1, 0 once mdbusy=0.
REQ-037 CNTW=4, stallD held high for 20 edges -> stallcount reaches 15 and holds at 15.
REQ-038 reset pulsed low between clock edges while mdbusy=1 and stallcount=7 -> mdbusy=0 and stallcount=0 without a clock edge; both stay 0 after release until new stimulus.
